// File: rtl/enemy_phase_controller_pkg.sv
// Shared enemy definitions: march FSM states, phase codes and the NONE position
// marker used by the row movers.
package enemy_phase_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CLEAR = 2'd3
   } marchState_t;

   // Row movers step left on 00/11 and right on 01/10
   typedef enum logic [1:0] {
      PH_LEFT0  = 2'b00,
      PH_RIGHT0 = 2'b01,
      PH_RIGHT1 = 2'b10,
      PH_LEFT1  = 2'b11
   } phase_t;

   localparam logic [9:0] POS_NONE = 10'h3FF;

   function automatic phase_t nextPhase(input phase_t ph);
      return phase_t'(ph + 2'd1);
   endfunction

endpackage

// File: rtl/enemy_alive_counter.sv
// Registered popcount of the enemy alive bitmap.
module enemy_alive_counter
   import enemy_phase_controller_pkg::*;
#(
   parameter int NUM_ENEMIES = 24,
   parameter int COUNT_W     = $clog2(NUM_ENEMIES + 1)
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic [NUM_ENEMIES-1:0] i_EnemyAlive,
   output logic [COUNT_W-1:0]     o_AliveCount
);

   logic [COUNT_W-1:0] popCount;

   always_comb begin
      popCount = '0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
         popCount = popCount + COUNT_W'(i_EnemyAlive[i]);
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) o_AliveCount <= '0;
      else       o_AliveCount <= popCount;
   end

endmodule

// File: rtl/enemy_phase_controller.sv
// Enemy formation march sequencer: frame-tick interval timer, move strobe,
// step/phase advance and wave-clear detection.
//
//   state    | meaning
//   ST_IDLE  | after reset, waiting for i_Start
//   ST_RUN   | counting frame ticks and issuing move strobes
//   ST_HOLD  | paused, all counters frozen
//   ST_CLEAR | no enemy left, waiting for i_Start
module enemy_phase_controller
   import enemy_phase_controller_pkg::*;
#(
   parameter int NUM_ENEMIES     = 24,
   parameter int FRAMES_MAX      = 8,
   parameter int FRAMES_MID      = 5,
   parameter int FRAMES_MIN      = 2,
   parameter int FAST_THRESHOLD  = 6,
   parameter int STEPS_PER_PHASE = 32
) (
   input  logic                               i_Clk,
   input  logic                               i_Rst,
   input  logic                               i_Start,
   input  logic                               i_Pause,
   input  logic                               i_FrameTick,
   input  logic [NUM_ENEMIES-1:0]             i_EnemyAlive,
   output logic [1:0]                         o_PhaseState,
   output logic                               o_MoveStrobe,
   output logic [$clog2(NUM_ENEMIES+1)-1:0]   o_AliveCount,
   output logic                               o_Running,
   output logic                               o_Cleared
);

   localparam int COUNT_W = $clog2(NUM_ENEMIES + 1);
   localparam int FRAME_W = $clog2(FRAMES_MAX + 1);
   localparam int STEP_W  = $clog2(STEPS_PER_PHASE);

   marchState_t        state, stateNext;
   logic [FRAME_W-1:0] frameCnt, frameNext, lastFrame;
   logic [STEP_W-1:0]  stepCnt, stepNext;
   phase_t             phase, phaseNext;
   logic               strobeNext;
   logic [COUNT_W-1:0] aliveCount;

   enemy_alive_counter #(
      .NUM_ENEMIES (NUM_ENEMIES),
      .COUNT_W     (COUNT_W)
   ) u_aliveCounter (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_EnemyAlive (i_EnemyAlive),
      .o_AliveCount (aliveCount)
   );

   // Terminal frame count shrinks as the formation thins out
   always_comb begin
      if (aliveCount > COUNT_W'(NUM_ENEMIES / 2))
         lastFrame = FRAME_W'(FRAMES_MAX - 1);
      else if (aliveCount > COUNT_W'(FAST_THRESHOLD))
         lastFrame = FRAME_W'(FRAMES_MID - 1);
      else
         lastFrame = FRAME_W'(FRAMES_MIN - 1);
   end

   always_comb begin
      stateNext  = state;
      frameNext  = frameCnt;
      stepNext   = stepCnt;
      phaseNext  = phase;
      strobeNext = 1'b0;

      if (o_MoveStrobe) begin
         if (stepCnt == STEP_W'(STEPS_PER_PHASE - 1)) begin
            stepNext  = '0;
            phaseNext = nextPhase(phase);
         end else begin
            stepNext = stepCnt + STEP_W'(1);
         end
      end

      case (state)
         ST_IDLE, ST_CLEAR: begin
            if (i_Start) begin
               stateNext = ST_RUN;
               frameNext = '0;
               stepNext  = '0;
               phaseNext = PH_LEFT0;
            end
         end
         ST_RUN: begin
            if (aliveCount == '0) begin
               stateNext = ST_CLEAR;
            end else if (i_Pause) begin
               stateNext = ST_HOLD;
            end else if (i_FrameTick) begin
               // >= lets a freshly shortened interval fire on the next tick
               if (frameCnt >= lastFrame) begin
                  frameNext  = '0;
                  strobeNext = 1'b1;
               end else begin
                  frameNext = frameCnt + FRAME_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (aliveCount == '0) stateNext = ST_CLEAR;
            else if (!i_Pause)    stateNext = ST_RUN;
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state        <= ST_IDLE;
         frameCnt     <= '0;
         stepCnt      <= '0;
         phase        <= PH_LEFT0;
         o_MoveStrobe <= 1'b0;
         o_Running    <= 1'b0;
         o_Cleared    <= 1'b0;
      end else begin
         state        <= stateNext;
         frameCnt     <= frameNext;
         stepCnt      <= stepNext;
         phase        <= phaseNext;
         o_MoveStrobe <= strobeNext;
         o_Running    <= (stateNext == ST_RUN);
         o_Cleared    <= (stateNext == ST_CLEAR);
      end
   end

   assign o_PhaseState = phase;
   assign o_AliveCount = aliveCount;

endmodule

// File: doc/enemy_phase_controller.md
# enemy_phase_controller

Sequencer for the enemy formation's horizontal march. It counts frame ticks and issues a one-cycle move strobe at an interval that shortens as enemies die. It advances the 2-bit phase that every row mover decodes: 00/11 mean step left, 01/10 mean step right. It sits between the frame timing generator and the per-row enemy move/position registers, and flags wave-clear when no enemy remains.

## Interface
- NUM_ENEMIES, 24: width of the alive bitmap.
- FRAMES_MAX, 8: frames per step while alive count > NUM_ENEMIES/2.
- FRAMES_MID, 5: frames per step while FAST_THRESHOLD < alive count ≤ NUM_ENEMIES/2.
- FRAMES_MIN, 2: frames per step while alive count ≤ FAST_THRESHOLD.
- FAST_THRESHOLD, 6: alive count at or below which FRAMES_MIN applies.
- STEPS_PER_PHASE, 32: strobes per phase before the phase advances.
- i_Clk  in  1  system clock; single clock domain.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Start  in  1  pulse; starts or restarts a wave from IDLE/CLEAR.
- i_Pause  in  1  level; freezes marching while high.
- i_FrameTick  in  1  one-cycle pulse per video frame.
- i_EnemyAlive  in  NUM_ENEMIES  per-enemy alive bits (1 = alive).
- o_PhaseState  out  2  current march phase.
- o_MoveStrobe  out  1  one-cycle pulse; row position registers update on it.
- o_AliveCount  out  $clog2(NUM_ENEMIES+1)  registered popcount of i_EnemyAlive.
- o_Running  out  1  high in RUN.
- o_Cleared  out  1  high in CLEAR.

## Operation
- The FSM has four states: IDLE, RUN, HOLD and CLEAR. Reset enters IDLE.
- IDLE/CLEAR + i_Start: enter RUN. Frame counter, step counter and phase all clear to 0. i_Start is ignored in RUN and HOLD.
- RUN + i_Pause: enter HOLD. HOLD + !i_Pause: return to RUN. Counters are frozen in HOLD.
- RUN or HOLD with o_AliveCount == 0: enter CLEAR next cycle. This check has priority over pause and over tick. Any strobe not yet issued is suppressed.
- Interval selection uses the registered o_AliveCount:
  - count > NUM_ENEMIES/2 (integer division): FRAMES_MAX.
  - count > FAST_THRESHOLD: FRAMES_MID.
  - otherwise: FRAMES_MIN.
- The interval is re-evaluated every tick. If the frame counter is already ≥ the new interval−1, the next tick fires.
- A tick in RUN with frame counter == interval−1 (or greater, per the rule above): the counter resets to 0 and o_MoveStrobe is registered high for the next cycle. Otherwise the counter increments.
- A tick in the same cycle as i_Pause rising is ignored, because HOLD takes effect.
- Step and phase advance happen on the clock edge that ends a strobe cycle. The step counter increments. At STEPS_PER_PHASE−1 it wraps to 0 and o_PhaseState advances 00→01→10→11→00.
- The phase sequence gives left, right, right, left, so net displacement per full cycle is zero.
- Counter widths: frame counter $clog2(FRAMES_MAX+1) bits, step counter $clog2(STEPS_PER_PHASE) bits. Unsigned, no saturation needed.

## Timing
- Reset values: o_PhaseState=00, o_MoveStrobe=0, o_AliveCount=0, o_Running=0, o_Cleared=0. All counters are 0.
- o_AliveCount lags i_EnemyAlive by 1 cycle.
- o_MoveStrobe rises 1 cycle after the qualifying i_FrameTick and lasts exactly 1 cycle.
- o_PhaseState is stable throughout every strobe cycle. A phase change becomes visible the cycle after the last strobe of the phase.
- The CLEAR decision lands 2 cycles after the last alive bit falls: 1 cycle for the count register, 1 for the FSM.
- o_Running and o_Cleared are registered and track the state with no added delay.
- An asynchronous reset mid-wave clears everything immediately, with no strobe glitch.

## Structure
- A shared enemy definitions package/include holds:
  - the FSM state encodings;
  - the phase encodings (PH_LEFT0=00, PH_RIGHT0=01, PH_RIGHT1=10, PH_LEFT1=11);
  - the NONE position constant 10'h3FF, shared with the row movers.
- Sub-module enemy_alive_counter: parameterised popcount of the alive bitmap with a registered output, on the same clock and reset.

## Test plan
- Reset, then i_Start with all 24 alive and 9 ticks → first strobe appears 1 cycle after tick 8; o_PhaseState=00 during it.
- 32 strobes at 24 alive → the phase reads 00 during strobe 32 and 01 the cycle after; 128 strobes return the phase to 00.
- Alive count dropped to 12 → strobe every 5 ticks; dropped to 6 → strobe every 2 ticks.
- Count dropped from 24 to 6 when frame counter=4 (interval 2) → the next tick fires, then the counter resets.
- i_Pause high for 20 ticks mid-phase → no strobe, counters frozen. After release, counting resumes from the frozen value.
- All alive bits cleared during RUN → o_Cleared=1 two cycles later, no further strobes. i_Start → RUN with phase 00.
- i_Rst asserted one cycle before a pending strobe → the strobe never appears and all outputs go to reset values.
